down_counter_timer: RTL



---
 rtl/counter_pkg.sv | 16 +
 rtl/down_counter_timer.sv | 107 ++++++++++
 2 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the down-counter / timer.
//   state_t   : controller state, 2-bit encoding
//   calc_max  : all-ones value for a given counter width (2^w - 1)
package counter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

   function automatic longint unsigned calc_max(input int unsigned w);
      return (64'd1 << w) - 64'd1;
   endfunction

endpackage

// File: rtl/down_counter_timer.sv
// Down-counter / timer.
// Free-runs downward after reset (wrapping 0 -> MAX with a borrow pulse);
// once loaded it behaves as a one-shot or auto-reload timer.
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous reset, active-high
//   en           count enable, one step per enabled edge
//   load         load strobe, captures load_val and enters timer mode
//   load_val     load/reload value
//   auto_reload  sampled at expiry: 1 = reload, 0 = stop in DONE
//   cnt          current count (registered)
//   bout         borrow/expiry pulse (registered, one cycle per event)
//   done         one-shot expired flag, held until load or rst
//
// state | meaning
// ------+-----------------------------------------------
// IDLE  | free-running down-counter, borrow on 0 -> MAX
// RUN   | timer counting down to 0 from a loaded value
// DONE  | one-shot expired; cnt parked at 0, en ignored
module down_counter_timer
   import counter_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             auto_reload,
   output logic [WIDTH-1:0] cnt,
   output logic             bout,
   output logic             done
);

   localparam logic [WIDTH-1:0] MAX  = WIDTH'(calc_max(WIDTH));
   localparam logic [WIDTH-1:0] ZERO = '0;
   localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

   state_t           state, state_nxt;
   logic [WIDTH-1:0] reload_q, reload_nxt;
   logic [WIDTH-1:0] cnt_nxt;
   logic             bout_nxt;
   logic             done_nxt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= ZERO;
         reload_q <= ZERO;
         bout     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         reload_q <= reload_nxt;
         bout     <= bout_nxt;
         done     <= done_nxt;
      end
   end

   // bout defaults low so it can only ever be a single-edge pulse unless
   // the expiry condition recurs on consecutive enabled edges.
   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      reload_nxt = reload_q;
      bout_nxt   = 1'b0;
      done_nxt   = done;

      if (load) begin
         cnt_nxt    = load_val;
         reload_nxt = load_val;
         done_nxt   = 1'b0;
         state_nxt  = RUN;
      end else if (en) begin
         case (state)
            IDLE: begin
               cnt_nxt  = (cnt == ZERO) ? MAX : cnt - ONE;
               bout_nxt = (cnt == ZERO);
            end
            RUN: begin
               if (cnt != ZERO) begin
                  cnt_nxt = cnt - ONE;
               end else begin
                  bout_nxt = 1'b1;
                  if (auto_reload) begin
                     cnt_nxt = reload_q;
                  end else begin
                     done_nxt  = 1'b1;
                     state_nxt = DONE;
                  end
               end
            end
            DONE: begin
               cnt_nxt = ZERO;
            end
            default: begin
               state_nxt = IDLE;
               cnt_nxt   = ZERO;
               done_nxt  = 1'b0;
            end
         endcase
      end
   end

endmodule
